// File: rtl/burst_pkg.sv
// Shared types and default widths for the burst sequencer and its beat counter.
package burst_pkg;

    localparam int DEFAULT_ADDR_WIDTH    = 8;
    localparam int DEFAULT_COUNTER_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } burst_state_e;

endpackage

// File: rtl/beat_counter.sv
// Beat index counter with last-beat compare; it stops on the final beat so it never wraps.
module beat_counter
    import burst_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     inc,
    input  logic [COUNTER_WIDTH-1:0] len,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     last
);

    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !last) begin
            count_d = count_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == len);

endmodule

// File: rtl/burst_sequencer.sv
// Burst address sequencer: IDLE -> BURST (one beat per handshake) -> DONE pulse -> IDLE.
// Optional abort input/aborted output are built when BURST_SEQ_ABORT_EN is defined.
module burst_sequencer
    import burst_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     start_ready,
    input  logic [ADDR_WIDTH-1:0]    start_addr,
    input  logic [COUNTER_WIDTH-1:0] burst_len,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic [COUNTER_WIDTH-1:0] beat_idx,
    output logic                     last,
    output logic                     busy,
    output logic                     done
`ifdef BURST_SEQ_ABORT_EN
    ,
    input  logic                     abort,
    output logic                     aborted
`endif
);

    burst_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_base_q, addr_base_d;
    logic [COUNTER_WIDTH-1:0] len_q, len_d;
    logic                     aborted_q, aborted_d;

    logic                     cnt_clear;
    logic                     cnt_inc;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic                     cnt_last;
    logic                     abort_req;

`ifdef BURST_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    beat_counter #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_beat_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .len   (len_q),
        .count (cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        addr_base_d = addr_base_q;
        len_d       = len_q;
        aborted_d   = aborted_q;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_base_d = start_addr;
                    len_d       = burst_len;
                    aborted_d   = 1'b0;
                    cnt_clear   = 1'b1;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_ready) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end
                end
                // An abort that coincides with the final handshake is a normal completion.
                if (abort_req && !(beat_ready && cnt_last)) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_base_q <= '0;
            len_q       <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_base_q <= addr_base_d;
            len_q       <= len_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        start_ready = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        beat_valid  = 1'b0;
        addr        = '0;
        beat_idx    = '0;
        last        = 1'b0;
        if (state_q == ST_BURST) begin
            beat_valid = 1'b1;
            addr       = addr_base_q + ADDR_WIDTH'(cnt);
            beat_idx   = cnt;
            last       = cnt_last;
        end
    end

`ifdef BURST_SEQ_ABORT_EN
    assign aborted = (state_q == ST_DONE) && aborted_q;
`endif

endmodule

// File: tb/tb_burst_sequencer.sv
// Directed bench for burst_sequencer; abort cases are exercised when BURST_SEQ_ABORT_EN is defined.
module tb_burst_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start_ready;
    logic [7:0] start_addr;
    logic [3:0] burst_len;
    logic       beat_valid;
    logic       beat_ready;
    logic [7:0] addr;
    logic [3:0] beat_idx;
    logic       last;
    logic       busy;
    logic       done;
`ifdef BURST_SEQ_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    burst_sequencer #(
        .ADDR_WIDTH    (8),
        .COUNTER_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_ready (start_ready),
        .start_addr  (start_addr),
        .burst_len   (burst_len),
        .beat_valid  (beat_valid),
        .beat_ready  (beat_ready),
        .addr        (addr),
        .beat_idx    (beat_idx),
        .last        (last),
        .busy        (busy),
        .done        (done)
`ifdef BURST_SEQ_ABORT_EN
        ,
        .abort       (abort),
        .aborted     (aborted)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one burst, then walk it beat by beat against a hand-computed address/index model.
    // With stall set, beat_ready follows 1,0,0,1,0,0,... and start is raised during stalls.
    task automatic do_burst(input logic [7:0] a, input logic [3:0] len, input bit stall);
        int         idx;
        int         k;
        logic       rdy;
        logic [7:0] ea;
        idx = 0;
        k = 0;
        check("accept_ready", start_ready, 1);
        start      = 1'b1;
        start_addr = a;
        burst_len  = len;
        beat_ready = 1'b0;
        step();
        start      = 1'b0;
        start_addr = 8'h00;
        burst_len  = 4'h0;
        while (idx <= int'(len) && k < 200) begin
            rdy = stall ? (k % 3 == 0) : 1'b1;
            ea  = a + 8'(idx);
            check("beat_valid", beat_valid, 1);
            check("beat_addr", addr, ea);
            check("beat_idx", beat_idx, idx);
            check("beat_last", last, (idx == int'(len)));
            check("beat_busy", busy, 1);
            check("beat_ready_low", start_ready, 0);
            beat_ready = rdy;
            start      = stall && !rdy;
            step();
            if (rdy) idx++;
            k++;
        end
        if (k >= 200) check("burst_timeout", 1, 0);
        beat_ready = 1'b0;
        start      = 1'b0;
        $display("[TB] burst addr=%0h len=%0d stall=%0d beats=%0d cycles=%0d", a, len, stall, idx, k);
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_valid", beat_valid, 0);
        check("done_addr", addr, 0);
        check("done_idx", beat_idx, 0);
        check("done_last", last, 0);
`ifdef BURST_SEQ_ABORT_EN
        check("done_not_aborted", aborted, 0);
`endif
        step();
        check("done_once", done, 0);
        check("back_idle", start_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = 8'h00;
        burst_len  = 4'h0;
        beat_ready = 1'b0;
`ifdef BURST_SEQ_ABORT_EN
        abort      = 1'b0;
`endif
        step();
        step();
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", beat_valid, 0);
        check("rst_addr", addr, 0);
        check("rst_idx", beat_idx, 0);
        check("rst_last", last, 0);
        $display("[TB] reset state checked");
        rst = 1'b0;
        step();

        do_burst(8'h10, 4'd3, 1'b0);
        do_burst(8'hFE, 4'd3, 1'b0);
        do_burst(8'h20, 4'd0, 1'b0);
        do_burst(8'h30, 4'd15, 1'b0);
        do_burst(8'h50, 4'd3, 1'b1);

        // Reset in the middle of an 8-beat burst.
        start      = 1'b1;
        start_addr = 8'h40;
        burst_len  = 4'd7;
        step();
        start      = 1'b0;
        beat_ready = 1'b1;
        step();
        step();
        check("mid_idx", beat_idx, 2);
        check("mid_addr", addr, 8'h42);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        beat_ready = 1'b0;
        check("mid_rst_ready", start_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", beat_valid, 0);
        step();
        check("mid_rst_no_done", done, 0);
        $display("[TB] reset mid-burst checked");
        do_burst(8'h60, 4'd2, 1'b0);

`ifdef BURST_SEQ_ABORT_EN
        start      = 1'b1;
        start_addr = 8'h80;
        burst_len  = 4'd7;
        step();
        start      = 1'b0;
        beat_ready = 1'b1;
        step();
        step();
        check("abt_idx", beat_idx, 2);
        abort = 1'b1;
        step();
        abort      = 1'b0;
        beat_ready = 1'b0;
        check("abt_done", done, 1);
        check("abt_aborted", aborted, 1);
        check("abt_valid", beat_valid, 0);
        step();
        check("abt_idle", start_ready, 1);
        check("abt_done_off", done, 0);
        check("abt_aborted_off", aborted, 0);
        $display("[TB] abort at beat 2 checked");

        start      = 1'b1;
        start_addr = 8'h90;
        burst_len  = 4'd1;
        step();
        start      = 1'b0;
        beat_ready = 1'b1;
        step();
        check("abl_last", last, 1);
        abort = 1'b1;
        step();
        abort      = 1'b0;
        beat_ready = 1'b0;
        check("abl_done", done, 1);
        check("abl_aborted", aborted, 0);
        step();
        check("abl_idle", start_ready, 1);
        $display("[TB] abort on last beat checked");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
